// File: rtl/md6_pad_responder.sv
// Mega Drive DB9 pad, device side: answers host SELECT toggles with the 3-/6-button
// pin patterns built from a 12-bit active-high button word.
module md6_pad_responder #(
  parameter int unsigned TIMEOUT_CYC = 18000,
  parameter bit          SIX_BUTTON  = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        md_sel,
  output logic [5:0]  pad_n,
  output logic [2:0]  phase
);

  localparam int unsigned     TmrW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmrW-1:0] TmrSat   = TmrW'(TIMEOUT_CYC);
  localparam logic [TmrW-1:0] TmrExp   = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      PhaseMax = SIX_BUTTON ? 3'd4 : 3'd2;

  logic            r_sel_meta;
  logic            r_sel_s;
  logic            r_sel_s_d;
  logic            w_fall;
  logic            w_rise;
  logic            w_edge;
  logic            w_expire;
  logic [2:0]      r_phase;
  logic [2:0]      w_phase_d;
  logic [TmrW-1:0] r_tmr;
  logic [TmrW-1:0] w_tmr_d;
  logic [5:0]      r_pad_n;
  logic [5:0]      w_pad_d;
  logic [11:0]     w_b;

  // SELECT is asynchronous to clk_sys; r_sel_s_d only serves edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sel_meta <= 1'b1;
      r_sel_s    <= 1'b1;
      r_sel_s_d  <= 1'b1;
    end else begin
      r_sel_meta <= md_sel;
      r_sel_s    <= r_sel_meta;
      r_sel_s_d  <= r_sel_s;
    end
  end

  always_comb begin
    w_fall   = r_sel_s_d & ~r_sel_s;
    w_rise   = ~r_sel_s_d & r_sel_s;
    w_edge   = w_fall | w_rise;
    w_expire = ~w_edge && (r_tmr == TmrExp);
  end

  // State register: low-count and idle timer.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_phase <= 3'd0;
      r_tmr   <= '0;
    end else begin
      r_phase <= w_phase_d;
      r_tmr   <= w_tmr_d;
    end
  end

  // Next-state: an edge in the expiry cycle takes priority over the restart.
  always_comb begin
    w_phase_d = r_phase;
    if (w_fall) begin
      if (r_phase < PhaseMax) begin
        w_phase_d = r_phase + 3'd1;
      end
    end else if (w_expire) begin
      w_phase_d = 3'd0;
    end

    w_tmr_d = r_tmr;
    if (w_edge) begin
      w_tmr_d = '0;
    end else if (r_tmr != TmrSat) begin
      w_tmr_d = r_tmr + 1'b1;
    end
  end

  // Output decode uses the next phase so pins and phase update on the same edge.
  always_comb begin
    w_b = ~buttons;
    if (r_sel_s) begin
      if (w_phase_d == 3'd3) begin
        w_pad_d = {w_b[5], w_b[4], w_b[8], w_b[9], w_b[10], w_b[11]};
      end else begin
        w_pad_d = {w_b[5], w_b[4], w_b[0], w_b[1], w_b[2], w_b[3]};
      end
    end else begin
      unique case (w_phase_d)
        3'd3:    w_pad_d = {w_b[7], w_b[6], 4'b0000};
        3'd4:    w_pad_d = {w_b[7], w_b[6], 4'b1111};
        default: w_pad_d = {w_b[7], w_b[6], 2'b00, w_b[2], w_b[3]};
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pad_n <= 6'h3F;
    end else begin
      r_pad_n <= w_pad_d;
    end
  end

  assign pad_n = r_pad_n;
  assign phase = r_phase;

endmodule

// File: tb/tb_md6_pad_responder.sv
// Bench for md6_pad_responder: 6- and 3-button instances share stimulus and are
// checked every cycle against a behavioural model plus hand-computed pin patterns.
module tb_md6_pad_responder;

  localparam int unsigned To = 100;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        md_sel;
  logic [11:0] buttons;
  logic [5:0]  pad6;
  logic [2:0]  ph6;
  logic [5:0]  pad3;
  logic [2:0]  ph3;

  int checks   = 0;
  int failures = 0;

  md6_pad_responder #(.TIMEOUT_CYC(To), .SIX_BUTTON(1'b1)) u_dut6 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .buttons (buttons),
    .md_sel  (md_sel),
    .pad_n   (pad6),
    .phase   (ph6)
  );

  md6_pad_responder #(.TIMEOUT_CYC(To), .SIX_BUTTON(1'b0)) u_dut3 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .buttons (buttons),
    .md_sel  (md_sel),
    .pad_n   (pad3),
    .phase   (ph3)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Pin pattern for a given synchronized SELECT level and low-count.
  function automatic logic [5:0] table_pad(input bit sel, input int ph, input logic [11:0] btn);
    logic [11:0] b;
    b = ~btn;
    if (sel && ph != 3) return {b[5], b[4], b[0], b[1], b[2], b[3]};
    if (sel)            return {b[5], b[4], b[8], b[9], b[10], b[11]};
    if (ph == 3)        return {b[7], b[6], 4'b0000};
    if (ph == 4)        return {b[7], b[6], 4'b1111};
    return {b[7], b[6], 2'b00, b[2], b[3]};
  endfunction

  function automatic int next_phase(input int ph, input bit fall, input bit expire, input int cap);
    if (fall)   return (ph + 1 > cap) ? cap : ph + 1;
    if (expire) return 0;
    return ph;
  endfunction

  // Model: md_sel seen through a 2-cycle delay; edges counted on that delayed copy.
  bit         m_s1, m_s2, m_s3, m_valid = 1'b0;
  bit         m_fall, m_rise, m_expire;
  int         m_idle, m_ph6, m_ph3;
  logic [5:0] m_pad6, m_pad3;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1;
      m_idle = 0; m_ph6 = 0; m_ph3 = 0;
      m_pad6 = 6'h3F; m_pad3 = 6'h3F;
    end else begin
      m_fall   = m_s3 && !m_s2;
      m_rise   = !m_s3 && m_s2;
      m_expire = !(m_fall || m_rise) && (m_idle == To - 1);
      m_ph6    = next_phase(m_ph6, m_fall, m_expire, 4);
      m_ph3    = next_phase(m_ph3, m_fall, m_expire, 2);
      if (m_fall || m_rise) m_idle = 0;
      else if (m_idle < To) m_idle = m_idle + 1;
      m_pad6 = table_pad(m_s2, m_ph6, buttons);
      m_pad3 = table_pad(m_s2, m_ph3, buttons);
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = md_sel;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      check("model_pad6", pad6, m_pad6);
      check("model_phase6", {3'b000, ph6}, 6'(m_ph6));
      check("model_pad3", pad3, m_pad3);
      check("model_phase3", {3'b000, ph3}, 6'(m_ph3));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic pulse(input int n);
    md_sel = 1'b0;
    tick(n);
    md_sel = 1'b1;
    tick(n);
  endtask

  initial begin
    reset   = 1'b1;
    md_sel  = 1'b1;
    buttons = 12'h000;
    tick(2);
    check("reset_pad", pad6, 6'h3F);
    check("reset_phase", {3'b000, ph6}, 6'd0);

    // Idle with B pressed
    buttons = 12'h010;
    reset   = 1'b0;
    tick(1);
    check("idle_first", pad6, 6'b101111);
    tick(5);
    check("idle_pad", pad6, 6'b101111);
    check("idle_phase", {3'b000, ph6}, 6'd0);

    // 3-button read, latency 3
    buttons = 12'h0C0;
    tick(1);
    md_sel = 1'b0;
    tick(2);
    check("t2_latency", pad6, 6'b111111);
    tick(1);
    check("t2_pad", pad6, 6'b000011);
    check("t2_phase", {3'b000, ph6}, 6'd1);
    md_sel = 1'b1;
    tick(10);

    // 6-button sequence
    buttons = 12'hF00;
    do_reset();
    pulse(10);
    pulse(10);
    md_sel = 1'b0;
    tick(10);
    check("t3_low3_pad", pad6, 6'b110000);
    check("t3_low3_phase", {3'b000, ph6}, 6'd3);
    check("t3_3btn_low3", pad3, 6'b110011);
    check("t3_3btn_phase", {3'b000, ph3}, 6'd2);
    md_sel = 1'b1;
    tick(10);
    check("t3_high3_pad", pad6, 6'b110000);
    check("t3_3btn_high3", pad3, 6'b111111);
    md_sel = 1'b0;
    tick(10);
    check("t3_low4_pad", pad6, 6'b111111);
    check("t3_low4_phase", {3'b000, ph6}, 6'd4);
    check("t3_3btn_low4", pad3, 6'b110011);
    check("t3_3btn_sat", {3'b000, ph3}, 6'd2);
    md_sel = 1'b1;
    tick(10);

    // Timeout restarts the sequence
    do_reset();
    pulse(10);
    md_sel = 1'b0;
    tick(10);
    md_sel = 1'b1;
    tick(120);
    check("t4_timeout6", {3'b000, ph6}, 6'd0);
    check("t4_timeout3", {3'b000, ph3}, 6'd0);
    md_sel = 1'b0;
    tick(10);
    check("t4_next_pad", pad6, 6'b110011);
    check("t4_next_phase", {3'b000, ph6}, 6'd1);
    md_sel = 1'b1;
    tick(10);

    // Fall lands exactly on the expiry cycle: edge wins
    do_reset();
    pulse(10);
    md_sel = 1'b0;
    tick(10);
    md_sel = 1'b1;
    tick(To);
    md_sel = 1'b0;
    tick(3);
    check("t5_phase", {3'b000, ph6}, 6'd3);
    check("t5_pad", pad6, 6'b110000);
    check("t5_3btn", {3'b000, ph3}, 6'd2);

    // Reset mid-sequence at phase 3
    md_sel = 1'b1;
    tick(10);
    check("t6_pre_phase", {3'b000, ph6}, 6'd3);
    buttons = 12'hF05;
    reset   = 1'b1;
    tick(1);
    check("t6_rst_pad", pad6, 6'h3F);
    check("t6_rst_phase", {3'b000, ph6}, 6'd0);
    reset = 1'b0;
    tick(1);
    check("t6_post_pad", pad6, 6'b110101);
    check("t6_post_phase", {3'b000, ph6}, 6'd0);

    // Button change reaches pins in one clock; opposing directions pass through
    buttons = 12'hF00;
    tick(1);
    check("btn_latency", pad6, 6'b111111);
    buttons = 12'h00F;
    tick(1);
    check("btn_opposing", pad6, 6'b110000);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
